// File: rtl/pwm_frame_scheduler.sv
// pwm_frame_scheduler
//
// Drives a serial-in / parallel-out PWM shift register. Each PWM step is one
// frame: CHANNELS shift cycles (channel CHANNELS-1 first, channel 0 last),
// then one latch cycle that moves the shift stage to the PWM outputs. The
// block owns the step counter (0..PERIOD-1) and a double-buffered duty table.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   reset_i         synchronous active-low reset
//   enable_i        run request, sampled in IDLE and LATCH only
//   cfg_we_i        duty write strobe (one cycle per write)
//   cfg_addr_i      channel index of the write
//   cfg_wdata_i     duty value in steps
//   shift_en_o      shift register advances this cycle
//   s_in_o          serial data bit for the shift register
//   latch_o         one-cycle transfer pulse to the PWM outputs
//   sr_clear_o      one-cycle active-high clear to the shift register
//   busy_o          FSM is not IDLE
//   period_start_o  pulse on the cycle step_cnt has just wrapped to 0
//   step_cnt_o      current step index
//   state_o         FSM state for observation (0 IDLE, 1 SHIFT, 2 LATCH)
//
// Config port: a write is accepted on every cycle cfg_we_i is high; there is
// no ready/back-pressure. Writes land in the shadow table; the active table
// is loaded from the shadow at the period wrap, so a period never mixes two
// duty values for one channel. In IDLE no frame is running, so writes go
// straight to both tables.
module pwm_frame_scheduler #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8,
    parameter int PERIOD   = 100
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        cfg_we_i,
    input  logic [$clog2(CHANNELS)-1:0] cfg_addr_i,
    input  logic [CNT_W-1:0]            cfg_wdata_i,
    output logic                        shift_en_o,
    output logic                        s_in_o,
    output logic                        latch_o,
    output logic                        sr_clear_o,
    output logic                        busy_o,
    output logic                        period_start_o,
    output logic [CNT_W-1:0]            step_cnt_o,
    output logic [1:0]                  state_o
);

    localparam int IDX_W = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  shadow_q [CHANNELS];
    logic [CNT_W-1:0]  shadow_d [CHANNELS];
    logic [CNT_W-1:0]  active_q [CNT_W > 0 ? CHANNELS : 1];
    logic [CNT_W-1:0]  active_d [CHANNELS];
    logic              period_start_q, period_start_d;
    logic              sr_clear_q, sr_clear_d;
    logic              wrap;
    logic              cfg_ok;
    logic              load_active;

    assign wrap   = (state_q == ST_LATCH) && (step_q == CNT_W'(PERIOD - 1));
    assign cfg_ok = (int'(cfg_addr_i) < CHANNELS);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        step_d         = step_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        period_start_d = 1'b0;
        sr_clear_d     = 1'b0;
        load_active    = 1'b0;
        shift_en_o     = 1'b0;
        s_in_o         = 1'b0;
        latch_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_SHIFT;
                    idx_d   = IDX_W'(CHANNELS - 1);
                end
            end
            ST_SHIFT: begin
                shift_en_o = 1'b1;
                s_in_o     = (step_q < active_q[idx_q]);
                if (idx_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_LATCH: begin
                latch_o = 1'b1;
                if (wrap) begin
                    step_d         = '0;
                    period_start_d = 1'b1;
                    load_active    = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
                if (enable_i) begin
                    state_d = ST_SHIFT;
                    idx_d   = IDX_W'(CHANNELS - 1);
                end else begin
                    // Stopping restarts the count from step 0, which is a new
                    // period, so pending shadow values are made active too.
                    state_d     = ST_IDLE;
                    step_d      = '0;
                    sr_clear_d  = 1'b1;
                    load_active = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cfg_we_i && cfg_ok) begin
            shadow_d[cfg_addr_i] = cfg_wdata_i;
            if (state_q == ST_IDLE) begin
                active_d[cfg_addr_i] = cfg_wdata_i;
            end
        end

        // Loading from shadow_d (not shadow_q) lets a write on the wrap
        // cycle reach the active table in the same edge.
        if (load_active) begin
            active_d = shadow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            step_q         <= '0;
            period_start_q <= 1'b0;
            sr_clear_q     <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            step_q         <= step_d;
            period_start_q <= period_start_d;
            sr_clear_q     <= sr_clear_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    assign sr_clear_o     = sr_clear_q;
    assign period_start_o = period_start_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign step_cnt_o     = step_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Directed bench for pwm_frame_scheduler at default parameters
// (8 channels, 8-bit counter, period 100). Inputs change just after the
// falling edge; outputs are sampled on the falling edge.
module tb_pwm_frame_scheduler;

  localparam int CH  = 8;
  localparam int PER = 100;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       enable;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       shift_en_o, s_in_o, latch_o, sr_clear_o, busy_o, period_start_o;
  logic [7:0] step_cnt_o;
  logic [1:0] state_o;

  pwm_frame_scheduler #(.CHANNELS(CH), .CNT_W(8), .PERIOD(PER)) dut (
    .clk_i          (clk),
    .reset_i        (reset_n),
    .enable_i       (enable),
    .cfg_we_i       (cfg_we),
    .cfg_addr_i     (cfg_addr),
    .cfg_wdata_i    (cfg_wdata),
    .shift_en_o     (shift_en_o),
    .s_in_o         (s_in_o),
    .latch_o        (latch_o),
    .sr_clear_o     (sr_clear_o),
    .busy_o         (busy_o),
    .period_start_o (period_start_o),
    .step_cnt_o     (step_cnt_o),
    .state_o        (state_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat_cnt = 0;
  int ps_cnt = 0;

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  int         exp_step;
  int         exp_active[CH];
  int         exp_shadow[CH];
  int         ones[CH];
  logic [7:0] step_bits[PER];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: sample at the falling edge, count pulses, retire a write strobe
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (latch_o === 1'b1) lat_cnt++;
    if (period_start_o === 1'b1) ps_cnt++;
    cfg_we = 1'b0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < CH; k++) begin
      exp_active[k] = 0;
      exp_shadow[k] = 0;
      ones[k] = 0;
    end
    exp_step = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    cfg_we  = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    tick();
    model_clear();
  endtask

  // write while IDLE: lands in shadow and active
  task automatic write_idle(input int a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_wdata = 8'(d);
    tick();
    exp_shadow[a] = d;
    exp_active[a] = d;
  endtask

  // arm a write for the coming rising edge; the next tick retires it
  task automatic arm_write(input int a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_wdata = 8'(d);
  endtask

  // Capture one frame: 8 shift cycles then a latch cycle. bits[k] = channel k.
  // drop_at >= 0 deasserts enable after observing that shift cycle.
  task automatic capture_step(input int drop_at, output logic [7:0] bits,
                              output int step_seen, output logic ok);
    int n;
    ok = 1'b1;
    bits = '0;
    n = 0;
    tick();
    while (shift_en_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (shift_en_o !== 1'b1) ok = 1'b0;
    step_seen = int'(step_cnt_o);
    for (int i = 0; i < CH; i++) begin
      if (i > 0) tick();
      if (shift_en_o !== 1'b1 || latch_o !== 1'b0) ok = 1'b0;
      bits[CH-1-i] = s_in_o;
      if (i == drop_at) enable = 1'b0;
    end
    tick();
    if (latch_o !== 1'b1 || shift_en_o !== 1'b0 || s_in_o !== 1'b0) ok = 1'b0;
  endtask

  function automatic logic [7:0] model_bits(input int step);
    logic [7:0] e;
    for (int k = 0; k < CH; k++) e[k] = (step < exp_active[k]);
    return e;
  endfunction

  task automatic run_steps(input int n, input string tag);
    for (int s = 0; s < n; s++) begin
      logic [7:0] bits;
      int         seen;
      logic       ok;
      exp_q.push_back(model_bits(exp_step));
      capture_step(-1, bits, seen, ok);
      check({tag, " frame"}, 32'(ok), 32'd1);
      check({tag, " step"}, 32'(seen), 32'(exp_step));
      check({tag, " bits"}, 32'(bits), 32'(exp_q.pop_front()));
      step_bits[exp_step] = bits;
      for (int k = 0; k < CH; k++) ones[k] += int'(bits[k]);
      if (exp_step == PER - 1) begin
        exp_step = 0;
        exp_active = exp_shadow;
      end else begin
        exp_step++;
      end
    end
  endtask

  task automatic clear_ones();
    for (int k = 0; k < CH; k++) ones[k] = 0;
  endtask

  initial begin
    int c0, p0, l0, seen, sum;
    logic [7:0] bits, e;
    logic ok;
    cfg_addr  = '0;
    cfg_wdata = '0;

    // reset state
    do_reset();
    check("rst shift_en", 32'(shift_en_o), 32'd0);
    check("rst s_in", 32'(s_in_o), 32'd0);
    check("rst latch", 32'(latch_o), 32'd0);
    check("rst period_start", 32'(period_start_o), 32'd0);
    check("rst sr_clear", 32'(sr_clear_o), 32'd1);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst step_cnt", 32'(step_cnt_o), 32'd0);
    check("rst state", 32'(state_o), 32'd0);
    release_reset();
    check("idle sr_clear", 32'(sr_clear_o), 32'd0);

    // basic run: duties 10,20,...,80
    for (int k = 0; k < CH; k++) write_idle(k, 10 * (k + 1));
    clear_ones();
    c0 = cyc;
    p0 = ps_cnt;
    enable = 1'b1;
    run_steps(PER, "basic");
    check("basic period cycles", 32'(cyc - c0), 32'd900);
    check("basic no early period_start", 32'(ps_cnt - p0), 32'd0);
    check("basic step0 bits", 32'(step_bits[0]), 32'h0ff);
    check("basic step10 bits", 32'(step_bits[10]), 32'h0fe);
    for (int k = 0; k < CH; k++) check($sformatf("basic ones ch%0d", k), 32'(ones[k]), 32'(10 * (k + 1)));
    run_steps(1, "basic wrap");
    check("basic period_start once", 32'(ps_cnt - p0), 32'd1);

    // extremes: 0, 100, 255
    do_reset();
    release_reset();
    write_idle(0, 0);
    write_idle(1, 100);
    write_idle(2, 255);
    clear_ones();
    l0 = lat_cnt;
    enable = 1'b1;
    run_steps(PER, "extreme");
    check("extreme latch count", 32'(lat_cnt - l0), 32'd100);
    check("extreme ones ch0", 32'(ones[0]), 32'd0);
    check("extreme ones ch1", 32'(ones[1]), 32'd100);
    check("extreme ones ch2", 32'(ones[2]), 32'd100);

    // shadowing: ch3 40 -> 90 written during step 50
    do_reset();
    release_reset();
    write_idle(3, 40);
    clear_ones();
    enable = 1'b1;
    run_steps(50, "shadow a");
    arm_write(3, 90);
    exp_shadow[3] = 90;
    run_steps(50, "shadow b");
    check("shadow old duty kept", 32'(ones[3]), 32'd40);
    clear_ones();
    p0 = ps_cnt;
    run_steps(PER, "shadow c");
    check("shadow new duty", 32'(ones[3]), 32'd90);
    check("shadow period_start", 32'(ps_cnt - p0), 32'd1);

    // boundary write on the wrap latch cycle: ch5 = 5
    arm_write(5, 5);
    exp_shadow[5] = 5;
    exp_active[5] = 5;
    clear_ones();
    run_steps(PER, "boundary");
    check("boundary ones ch5", 32'(ones[5]), 32'd5);
    check("boundary step4 ch5", 32'(step_bits[4][5]), 32'd1);
    check("boundary step5 ch5", 32'(step_bits[5][5]), 32'd0);
    check("boundary ones ch3", 32'(ones[3]), 32'd90);

    // disable mid-SHIFT
    do_reset();
    release_reset();
    for (int k = 0; k < CH; k++) write_idle(k, 3 * k);
    enable = 1'b1;
    run_steps(3, "dis pre");
    e = model_bits(3);
    capture_step(2, bits, seen, ok);
    check("dis frame completes", 32'(ok), 32'd1);
    check("dis step", 32'(seen), 32'd3);
    check("dis bits", 32'(bits), 32'(e));
    tick();
    check("dis busy", 32'(busy_o), 32'd0);
    check("dis sr_clear", 32'(sr_clear_o), 32'd1);
    check("dis step_cnt", 32'(step_cnt_o), 32'd0);
    check("dis shift_en", 32'(shift_en_o), 32'd0);
    tick();
    check("dis sr_clear one cycle", 32'(sr_clear_o), 32'd0);
    check("dis still idle", 32'(busy_o), 32'd0);
    exp_step = 0;
    exp_active = exp_shadow;
    enable = 1'b1;
    run_steps(2, "restart");

    // reset mid-SHIFT
    do_reset();
    release_reset();
    for (int k = 0; k < CH; k++) write_idle(k, 100);
    enable = 1'b1;
    run_steps(1, "rmid pre");
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sum += int'(shift_en_o === 1'b1);
    end
    check("rmid shift cycles seen", 32'(sum), 32'd4);
    reset_n = 1'b0;
    tick();
    check("rmid shift_en", 32'(shift_en_o), 32'd0);
    check("rmid latch", 32'(latch_o), 32'd0);
    check("rmid sr_clear", 32'(sr_clear_o), 32'd1);
    check("rmid busy", 32'(busy_o), 32'd0);
    check("rmid step_cnt", 32'(step_cnt_o), 32'd0);
    reset_n = 1'b1;
    model_clear();
    run_steps(PER, "rmid post");
    sum = 0;
    for (int k = 0; k < CH; k++) sum += ones[k];
    check("rmid duties cleared", 32'(sum), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
